// File: rtl/fir_tap_multi_vin_buffer.sv
// Multi-channel tap write buffer: each channel packs an addressed packet into its
// own beat buffer, and a round-robin write engine drains ready buffers to DDR.
module fir_tap_multi_vin_buffer #(
  parameter real TCQ           = 0.1,
  parameter int  CH_NUM        = 4,
  parameter int  ADDR_WIDTH    = 30,
  parameter int  DATA_WIDTH    = 32,
  parameter int  MEM_DATA_BITS = 256,
  parameter int  BURST_LEN     = 128
) (
  input  logic                           ddr_clk_i,
  input  logic                           ddr_rst_i,
  input  logic [CH_NUM-1:0]              tap_wr_cmd_i,
  input  logic [CH_NUM-1:0]              tap_wr_vld_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   tap_wr_data_i,
  output logic [CH_NUM-1:0]              tap_busy_o,
  output logic [CH_NUM-1:0]              tap_ovf_o,
  output logic                           wr_ddr_req_o,
  output logic [7:0]                     wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]          wr_ddr_addr_o,
  input  logic                           ddr_fifo_rd_req_i,
  output logic [MEM_DATA_BITS-1:0]       wr_ddr_data_o,
  input  logic                           wr_ddr_finish_i
);

  localparam int R   = MEM_DATA_BITS / DATA_WIDTH;
  localparam int WCW = (R > 1) ? $clog2(R) : 1;
  localparam int BIW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  // Clock-to-Q is a simulation-only notion; it never shapes the hardware.
  if (TCQ < 0.0) begin : g_tcq_neg
  end

  typedef enum logic [1:0] {C_IDLE, C_ADDR, C_FILL, C_READY} ch_state_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} wr_state_t;

  wr_state_t                r_state;
  logic [CW-1:0]            r_grant;
  logic [CW-1:0]            r_rr_start;
  logic [7:0]               r_rd_idx;

  logic [CH_NUM-1:0]        w_ready;
  logic [CH_NUM-1:0]        w_fin_ch;
  logic [ADDR_WIDTH-1:0]    w_ch_addr [CH_NUM];
  logic [7:0]               w_ch_len  [CH_NUM];
  logic [MEM_DATA_BITS-1:0] w_ch_beat [CH_NUM];
  logic [MEM_DATA_BITS-1:0] w_beat_sel;
  logic                     w_finish;
  logic                     w_found;
  logic [CW-1:0]            w_sel;
  logic [CW-1:0]            w_idx;

  assign w_finish   = wr_ddr_finish_i && ((r_state == S_REQ) || (r_state == S_DATA));
  assign w_beat_sel = w_ch_beat[r_grant];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    ch_state_t                r_st;
    logic                     r_cmd_d;
    logic                     r_busy;
    logic                     r_ovf;
    logic [WCW-1:0]           r_wcnt;
    logic [7:0]               r_beat;
    logic [7:0]               r_len;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [MEM_DATA_BITS-1:0] r_pack;
    logic [MEM_DATA_BITS-1:0] r_mem [BURST_LEN];

    logic                     w_cmd;
    logic                     w_vld;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_acc;
    logic                     w_beat_done;
    logic                     w_fall;
    logic                     w_we;
    logic [BIW-1:0]           w_widx;
    logic [MEM_DATA_BITS-1:0] w_pack_nxt;
    logic [MEM_DATA_BITS-1:0] w_wdata;

    assign w_cmd       = tap_wr_cmd_i[c];
    assign w_vld       = tap_wr_vld_i[c];
    assign w_data      = tap_wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
    // Words past a full buffer are not accepted; they only raise the overflow flag.
    assign w_acc       = (r_st == C_FILL) && w_cmd && w_vld && (r_beat < 8'(BURST_LEN));
    assign w_beat_done = w_acc && (r_wcnt == WCW'(R - 1));
    assign w_fall      = (r_st == C_FILL) && !w_cmd;
    assign w_we        = w_beat_done || (w_fall && (r_wcnt != '0));
    assign w_widx      = r_beat[BIW-1:0];
    assign w_wdata     = w_beat_done ? w_pack_nxt : r_pack;

    always_comb begin
      w_pack_nxt = r_pack;
      w_pack_nxt[int'(r_wcnt)*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end

    always_ff @(posedge ddr_clk_i) begin
      if (w_we) r_mem[w_widx] <= w_wdata;
    end

    always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
        r_st    <= C_IDLE;
        r_cmd_d <= 1'b0;
        r_busy  <= 1'b0;
        r_ovf   <= 1'b0;
        r_wcnt  <= '0;
        r_beat  <= '0;
        r_len   <= '0;
        r_addr  <= '0;
        r_pack  <= '0;
      end else begin
        r_cmd_d <= w_cmd;
        if (r_busy && !w_cmd && w_vld) r_ovf <= 1'b1;
        unique case (r_st)
          C_IDLE: begin
            if (w_cmd && !r_cmd_d) begin
              r_wcnt <= '0;
              r_beat <= '0;
              r_pack <= '0;
              if (w_vld) begin
                r_addr <= ADDR_WIDTH'(w_data);
                r_busy <= 1'b1;
                r_st   <= C_FILL;
              end else begin
                r_st   <= C_ADDR;
              end
            end
          end
          C_ADDR: begin
            if (!w_cmd) begin
              r_st <= C_IDLE;
            end else if (w_vld) begin
              r_addr <= ADDR_WIDTH'(w_data);
              r_busy <= 1'b1;
              r_st   <= C_FILL;
            end
          end
          C_FILL: begin
            if (w_cmd) begin
              if (w_vld && !w_acc) r_ovf <= 1'b1;
              if (w_beat_done) begin
                r_pack <= '0;
                r_wcnt <= '0;
                r_beat <= r_beat + 8'd1;
              end else if (w_acc) begin
                r_pack <= w_pack_nxt;
                r_wcnt <= r_wcnt + 1'b1;
              end
            end else begin
              r_len <= r_beat + ((r_wcnt != '0) ? 8'd1 : 8'd0);
              if ((r_beat == 8'd0) && (r_wcnt == '0)) begin
                r_busy <= 1'b0;
                r_st   <= C_IDLE;
              end else begin
                r_st   <= C_READY;
              end
            end
          end
          C_READY: begin
            if (w_fin_ch[c]) begin
              r_busy <= 1'b0;
              r_st   <= C_IDLE;
            end
          end
          default: r_st <= C_IDLE;
        endcase
      end
    end

    assign tap_busy_o[c] = r_busy;
    assign tap_ovf_o[c]  = r_ovf;
    assign w_ready[c]    = (r_st == C_READY);
    assign w_fin_ch[c]   = w_finish && (r_grant == CW'(c));
    assign w_ch_addr[c]  = r_addr;
    assign w_ch_len[c]   = r_len;
    assign w_ch_beat[c]  = r_mem[r_rd_idx[BIW-1:0]];
  end

  // Round-robin search beginning one past the most recent grant.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_idx = CW'((int'(r_rr_start) + i) % CH_NUM);
      if (!w_found && w_ready[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_rr_start    <= '0;
      r_rd_idx      <= '0;
      wr_ddr_req_o  <= 1'b0;
      wr_ddr_len_o  <= '0;
      wr_ddr_addr_o <= '0;
      wr_ddr_data_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant       <= w_sel;
            r_rr_start    <= (w_sel == CW'(CH_NUM - 1)) ? '0 : w_sel + 1'b1;
            r_rd_idx      <= '0;
            wr_ddr_req_o  <= 1'b1;
            wr_ddr_len_o  <= w_ch_len[w_sel];
            wr_ddr_addr_o <= w_ch_addr[w_sel];
            r_state       <= S_REQ;
          end
        end
        S_REQ, S_DATA: begin
          // Read index saturates on the last beat so over-reads repeat it.
          if (ddr_fifo_rd_req_i) begin
            wr_ddr_data_o <= w_beat_sel;
            if ((r_rd_idx + 8'd1) < wr_ddr_len_o) r_rd_idx <= r_rd_idx + 8'd1;
            r_state <= S_DATA;
          end
          if (wr_ddr_finish_i) begin
            wr_ddr_req_o <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_multi_vin_buffer.sv
// Directed bench for fir_tap_multi_vin_buffer with a scoreboard of expected DDR
// requests and beats, drained by a simple DDR-controller model.
module tb_fir_tap_multi_vin_buffer;

  localparam int CH = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MB = 256;
  localparam int BL = 128;
  localparam int R  = MB / DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    cmd;
  logic [CH-1:0]    vld;
  logic [CH*DW-1:0] wdata;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    ovf;
  logic             req;
  logic [7:0]       len;
  logic [AW-1:0]    addr;
  logic             rd_req;
  logic [MB-1:0]    rdata;
  logic             fin;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } req_t;

  req_t          req_q[$];
  logic [MB-1:0] beat_q[$];

  fir_tap_multi_vin_buffer #(
    .CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DATA_BITS(MB), .BURST_LEN(BL)
  ) dut (
    .ddr_clk_i(clk),
    .ddr_rst_i(rst),
    .tap_wr_cmd_i(cmd),
    .tap_wr_vld_i(vld),
    .tap_wr_data_i(wdata),
    .tap_busy_o(busy),
    .tap_ovf_o(ovf),
    .wr_ddr_req_o(req),
    .wr_ddr_len_o(len),
    .wr_ddr_addr_o(addr),
    .ddr_fifo_rd_req_i(rd_req),
    .wr_ddr_data_o(rdata),
    .wr_ddr_finish_i(fin)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_val(input int ch, input int rnd, input int k);
    return DW'((ch << 24) | (rnd << 16) | k);
  endfunction

  function automatic logic [AW-1:0] addr_val(input int ch, input int rnd);
    return AW'(32'h100 * (ch + 1) + 32'h1000 * rnd);
  endfunction

  task automatic push_expect(input int ch, input int rnd, input int nw);
    req_t          e;
    logic [MB-1:0] beat;
    int            kept;
    int            nb;
    kept   = (nw > BL * R) ? BL * R : nw;
    nb     = (kept + R - 1) / R;
    e.ch   = ch;
    e.addr = addr_val(ch, rnd);
    e.len  = 8'(nb);
    req_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int j = 0; j < R; j++)
        if (b * R + j < kept) beat[j*DW +: DW] = word_val(ch, rnd, b * R + j + 1);
      beat_q.push_back(beat);
    end
  endtask

  task automatic drive(input logic [CH-1:0] mask, input int nw, input int rnd);
    @(negedge clk);
    for (int c = 0; c < CH; c++)
      if (mask[c]) begin
        cmd[c] = 1'b1;
        vld[c] = 1'b1;
        wdata[c*DW +: DW] = DW'(addr_val(c, rnd));
      end
    for (int k = 1; k <= nw; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_rise", busy & mask, mask);
      for (int c = 0; c < CH; c++)
        if (mask[c]) wdata[c*DW +: DW] = word_val(c, rnd, k);
    end
    @(negedge clk);
    if (nw == 0) chk("busy_rise", busy & mask, mask);
    for (int c = 0; c < CH; c++)
      if (mask[c]) begin
        cmd[c] = 1'b0;
        vld[c] = 1'b0;
        wdata[c*DW +: DW] = '0;
        if (nw > 0) push_expect(c, rnd, nw);
      end
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("req_rise", req, 1'b1);
  endtask

  task automatic serve(input bit extra);
    req_t          e;
    logic [MB-1:0] last;
    last = '0;
    wait_req();
    chk("req_pending", req_q.size() > 0, 1'b1);
    if (req !== 1'b1 || req_q.size() == 0) return;
    e = req_q.pop_front();
    chk($sformatf("addr_ch%0d", e.ch), addr, e.addr);
    chk($sformatf("len_ch%0d", e.ch), len, e.len);
    for (int b = 0; b < int'(e.len); b++) begin
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      last = (beat_q.size() != 0) ? beat_q.pop_front() : '0;
      chk($sformatf("beat_ch%0d_%0d", e.ch, b), rdata, last);
    end
    if (extra) begin
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      chk("beat_past_len", rdata, last);
    end
    chk("len_stable", len, e.len);
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    chk("req_drop", req, 1'b0);
    chk($sformatf("busy_fall_ch%0d", e.ch), busy[e.ch], 1'b0);
    @(negedge clk);
  endtask

  initial begin
    req_t          e;
    logic [MB-1:0] b0;
    rst    = 1'b1;
    cmd    = '0;
    vld    = '0;
    wdata  = '0;
    rd_req = 1'b0;
    fin    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 1'b0);
    chk("rst_len", len, 8'd0);
    chk("rst_addr", addr, '0);
    chk("rst_data", rdata, '0);
    chk("rst_busy", busy, '0);
    chk("rst_ovf", ovf, '0);
    rst = 1'b0;

    // Stray word with no packet and no busy: silently ignored.
    @(negedge clk);
    vld[0] = 1'b1;
    wdata[DW-1:0] = 32'hdead;
    @(negedge clk);
    vld[0] = 1'b0;
    wdata = '0;
    @(negedge clk);
    chk("idle_vld_ovf", ovf, '0);
    chk("idle_vld_busy", busy, '0);

    // Finish pulse while idle must not disturb anything.
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_fin_req", req, 1'b0);

    // Two simultaneous rounds: both served 0,1,2,3.
    drive(4'hF, 9, 1);
    for (int i = 0; i < CH; i++) serve(1'b0);
    drive(4'hF, 12, 2);
    for (int i = 0; i < CH; i++) serve(1'b0);

    // ch0: 16 words 1..16 at 0x100.
    drive(4'b0001, 16, 0);
    serve(1'b0);

    // ch1: 10 words, then a dropped word while busy, plus an over-read.
    drive(4'b0010, 10, 0);
    @(negedge clk);
    vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    chk("busy_drop_ovf1", ovf[1], 1'b1);
    serve(1'b1);

    // ch3: address only, no request.
    drive(4'b1000, 0, 0);
    @(negedge clk);
    chk("addr_only_busy3", busy[3], 1'b0);
    repeat (5) @(negedge clk);
    chk("addr_only_noreq", req, 1'b0);

    // ch2: overflow past the buffer.
    drive(4'b0100, 1030, 0);
    @(negedge clk);
    chk("ovf2_set", ovf[2], 1'b1);
    serve(1'b0);
    chk("ovf_vector", ovf, 4'b0110);

    // Reset in the middle of a ch0 burst.
    drive(4'b0001, 16, 3);
    wait_req();
    e  = req_q.pop_front();
    b0 = beat_q.pop_front();
    chk("mid_addr", addr, e.addr);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("mid_beat0", rdata, b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", req, 1'b0);
    chk("midrst_len", len, 8'd0);
    chk("midrst_addr", addr, '0);
    chk("midrst_data", rdata, '0);
    chk("midrst_busy", busy, '0);
    chk("midrst_ovf", ovf, '0);
    req_q.delete();
    beat_q.delete();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("midrst_no_beat", rdata, '0);
    repeat (3) @(negedge clk);
    chk("midrst_noreq", req, 1'b0);

    // Fresh ch0 packet after reset.
    drive(4'b0001, 16, 4);
    serve(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_multi_vin_buffer.md
FIR_TAP_MULTI_VIN_BUFFER -- requirements
Module: fir_tap_multi_vin_buffer

Interface
REQ-001 Parameter TCQ, default 0.1, register clock-to-Q delay for simulation.
REQ-002 Parameter CH_NUM, default 4, number of independent tap-write channels (1..8).
REQ-003 Parameter ADDR_WIDTH, default 30, DDR address width.
REQ-004 Parameter DATA_WIDTH, default 32, channel word width; MEM_DATA_BITS/DATA_WIDTH = R shall be a power of two.
REQ-005 Parameter MEM_DATA_BITS, default 256, DDR beat width.
REQ-006 Parameter BURST_LEN, default 128, max beats per channel packet (<=255).
REQ-007 ddr_clk_i input 1, sole clock; all logic is synchronous to it.
REQ-008 ddr_rst_i input 1, reset; one clock, synchronous and active-high.
REQ-009 tap_wr_cmd_i input CH_NUM, per-channel packet window, high for the whole packet.
REQ-010 tap_wr_vld_i input CH_NUM, per-channel word strobe.
REQ-011 tap_wr_data_i input CH_NUM*DATA_WIDTH, channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 tap_busy_o output CH_NUM, channel holds a packet not yet written to DDR.
REQ-013 tap_ovf_o output CH_NUM, sticky overflow/drop flag per channel.
REQ-014 wr_ddr_req_o output 1, write request, held high until wr_ddr_finish_i.
REQ-015 wr_ddr_len_o output 8, beat count of current request.
REQ-016 wr_ddr_addr_o output ADDR_WIDTH, start address of current request.
REQ-017 ddr_fifo_rd_req_i input 1, DDR controller pulls one beat.
REQ-018 wr_ddr_data_o output MEM_DATA_BITS, beat data.
REQ-019 wr_ddr_finish_i input 1, single-cycle pulse, current request complete.

Function
REQ-020 Per channel: first tap_wr_vld_i word after tap_wr_cmd_i rises is the DDR start address (low ADDR_WIDTH bits kept); all later words while cmd high are payload.
REQ-021 Payload packed R words per beat, first word in bits [DATA_WIDTH-1:0]; beat written to that channel's buffer region (BURST_LEN beats) when R words collected.
REQ-022 On cmd falling edge a partial beat is zero-padded and stored; beat count = ceil(words/R); channel becomes READY the next cycle.
REQ-023 Payload words beyond BURST_LEN*R are dropped and tap_ovf_o[c] set; stored beats unaffected.
REQ-024 tap_busy_o[c] rises the cycle after the address word is captured and falls the cycle after wr_ddr_finish_i for that channel.
REQ-025 While tap_busy_o[c]=1 and cmd low, vld words on c are dropped and tap_ovf_o[c] set; a new cmd rise while busy is ignored until busy falls. vld while cmd low and not busy is ignored silently.
REQ-026 cmd fall with zero payload words (address only or none): no DDR request, tap_busy_o[c] falls next cycle.
REQ-027 Write FSM states IDLE, REQ, DATA, DONE: IDLE->REQ when any channel READY (grant latched); REQ->DATA same cycle as first ddr_fifo_rd_req_i; DATA->DONE on wr_ddr_finish_i; DONE->IDLE after one cycle clearing grant channel.
REQ-028 Grant is round-robin: search starts at last granted channel +1 modulo CH_NUM; after reset search starts at channel 0.
REQ-029 wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o registered; req asserts the cycle after IDLE grant (2 cycles after cmd fall at best); len/addr stable while req high.
REQ-030 wr_ddr_data_o presents the beat one cycle after each ddr_fifo_rd_req_i, beats in stored order; rd_req beyond len returns the last beat and is otherwise ignored.
REQ-031 wr_ddr_req_o deasserts the cycle after wr_ddr_finish_i; finish while IDLE ignored.
REQ-032 Channels keep accepting new packets while another channel bursts; buffers are per-channel, no cross-channel blocking.

Reset
REQ-033 ddr_rst_i high: FSM IDLE, wr_ddr_req_o=0, wr_ddr_len_o=0, wr_ddr_addr_o=0, wr_ddr_data_o=0, tap_busy_o=0, tap_ovf_o=0, packers/counters cleared, RR pointer to channel 0.
REQ-034 Reset mid-burst or mid-packet aborts all: req drops next cycle, buffered data discarded, no further beats.

Verification
REQ-035 ch0: addr 0x100, 16 words 1..16, cmd fall -> req, len=2, addr=0x100; beat0 words 1..8 low-to-high, beat1 9..16; busy[0] falls after finish.
REQ-036 ch1: addr 0x200, 10 words -> len=2, beat1 = words 9,10 in low 64 bits, upper 192 bits zero.
REQ-037 ch0..ch3 packets end same cycle -> requests served in order 0,1,2,3; next simultaneous round after last grant 3 starts at 0.
REQ-038 ch2: 1030 payload words -> len=128, words 1025..1030 dropped, tap_ovf_o[2]=1 and stays 1.
REQ-039 ch3: address only then cmd fall -> no req, busy[3] high 1-2 cycles then 0.
REQ-040 ddr_rst_i pulsed during DATA of ch0 -> req=0 next cycle, all outputs reset values, new ch0 packet after reset writes correctly.
